// File: rtl/io_port_bank.sv
// Input-port bank: per-channel 2-flop sync, debounce, zero-extend, sticky change flags.
// Optional interrupt output enabled by defining IO_PORT_IRQ_EN.
module io_port_ch #(
  parameter int IN_W       = 4,
  parameter int DATA_W     = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   raw,
  output logic [DATA_W-1:0] value,
  output logic              accept
);
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [IN_W-1:0]  s1, s2, stable;
  logic [CNT_W-1:0] cnt;

  // cnt counts cycles s2 has differed from stable; a third value does not restart it
  assign accept = (s2 != stable) && (cnt == CNT_MAX);
  assign value  = DATA_W'(stable);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module io_port_bank #(
  parameter int N_CH       = 3,
  parameter int IN_W       = 4,
  parameter int DATA_W     = 8,
  parameter int DEB_CYCLES = 4,
  parameter int SEL_W      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*IN_W-1:0]     in_raw,
  input  logic [SEL_W-1:0]         rd_sel,
  input  logic                     rd_ack,
`ifdef IO_PORT_IRQ_EN
  input  logic [N_CH-1:0]          irq_mask,
  output logic                     irq,
`endif
  output logic [N_CH*DATA_W-1:0]   port_data,
  output logic [N_CH-1:0]          changed
);
  logic [N_CH-1:0] set, changed_next;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    io_port_ch #(
      .IN_W       (IN_W),
      .DATA_W     (DATA_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .raw    (in_raw[k*IN_W +: IN_W]),
      .value  (port_data[k*DATA_W +: DATA_W]),
      .accept (set[k])
    );
  end

  // out-of-range rd_sel never matches a channel index; set beats a same-edge ack
  always_comb begin
    changed_next = changed;
    for (int k = 0; k < N_CH; k++) begin
      changed_next[k] = set[k] | (changed[k] & ~(rd_ack && (rd_sel == SEL_W'(k))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) changed <= '0;
    else       changed <= changed_next;
  end

`ifdef IO_PORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(changed_next & irq_mask);
  end
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: stimulus queues expected state per edge, monitor compares.
module tb_io_port_bank;
  localparam int N_CH = 3, IN_W = 4, DATA_W = 8, DEB = 4, SEL_W = 2;
  localparam logic [N_CH-1:0] MASK = 3'b010;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_CH*IN_W-1:0]   in_raw;
  logic [SEL_W-1:0]       rd_sel;
  logic                   rd_ack;
  logic [N_CH*DATA_W-1:0] port_data;
  logic [N_CH-1:0]        changed;
`ifdef IO_PORT_IRQ_EN
  logic [N_CH-1:0]        irq_mask;
  logic                   irq;
`endif

  io_port_bank #(
    .N_CH(N_CH), .IN_W(IN_W), .DATA_W(DATA_W), .DEB_CYCLES(DEB), .SEL_W(SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_raw    (in_raw),
    .rd_sel    (rd_sel),
    .rd_ack    (rd_ack),
`ifdef IO_PORT_IRQ_EN
    .irq_mask  (irq_mask),
    .irq       (irq),
`endif
    .port_data (port_data),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                     at;
    string                  name;
    logic [N_CH*DATA_W-1:0] pd;
    logic [N_CH-1:0]        ch;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void expect_at(int at, string name, logic [N_CH*DATA_W-1:0] pd,
                                    logic [N_CH-1:0] ch);
    exp_t e;
    e.at = at; e.name = name; e.pd = pd; e.ch = ch;
    q.push_back(e);
  endfunction

  // Monitor: state after edge N is sampled on the following falling edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      logic ok;
      logic exp_irq;
      e = q.pop_front();
      checks++;
      exp_irq = |(e.ch & MASK);
      ok = (e.at == cyc) && (port_data === e.pd) && (changed === e.ch);
`ifdef IO_PORT_IRQ_EN
      ok = ok && (irq === exp_irq);
`endif
      if (ok) passes++;
      else
        $display("FAIL %s @edge %0d (due %0d): port_data=%h changed=%b want port_data=%h changed=%b irq_want=%b",
                 e.name, cyc, e.at, port_data, changed, e.pd, e.ch, exp_irq);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    reset  = 1'b1;
    in_raw = '1;
    rd_sel = '0;
    rd_ack = 1'b0;
`ifdef IO_PORT_IRQ_EN
    irq_mask = MASK;
`endif
    // reset held two edges with all-ones inputs
    expect_at(1, "rst_e1", '0, '0);
    expect_at(2, "rst_e2", '0, '0);
    expect_at(3, "rst_release", '0, '0);
    tick(2);
    reset  = 1'b0;
    in_raw = '0;
    tick(1);

    // ch0 accepts 4'hA exactly 6 edges after the drive edge
    t = cyc;
    in_raw = {4'h0, 4'h0, 4'hA};
    expect_at(t + 5, "deb_early", 24'h000000, 3'b000);
    expect_at(t + 6, "deb_accept", 24'h00000A, 3'b001);
    tick(6);

    // ch1 3-cycle glitch never reaches acceptance
    t = cyc;
    in_raw = {4'h0, 4'h5, 4'hA};
    expect_at(t + 5, "glitch_e5", 24'h00000A, 3'b001);
    expect_at(t + 6, "glitch_e6", 24'h00000A, 3'b001);
    expect_at(t + 8, "glitch_e8", 24'h00000A, 3'b001);
    tick(3);
    in_raw = {4'h0, 4'h0, 4'hA};
    tick(5);

    // plain acknowledge of ch0
    t = cyc;
    rd_sel = 2'd0; rd_ack = 1'b1;
    expect_at(t + 1, "ack_ch0", 24'h00000A, 3'b000);
    tick(1);
    rd_ack = 1'b0;

    // ack on the same edge ch0 accepts 4'h3: set wins
    t = cyc;
    in_raw = {4'h0, 4'h0, 4'h3};
    expect_at(t + 5, "race_pre", 24'h00000A, 3'b000);
    expect_at(t + 6, "race_set_wins", 24'h000003, 3'b001);
    tick(5);
    rd_sel = 2'd0; rd_ack = 1'b1;
    tick(1);

    // out-of-range ack, then ack of another channel: ch0 flag untouched
    t = cyc;
    rd_sel = 2'd3;
    expect_at(t + 1, "ack_out_of_range", 24'h000003, 3'b001);
    expect_at(t + 2, "ack_other_ch", 24'h000003, 3'b001);
    tick(1);
    rd_sel = 2'd1;
    tick(1);
    rd_ack = 1'b0;

    // ch2 debouncing 4'hF (cnt=2) when reset hits; then full re-acceptance
    t = cyc;
    in_raw = {4'hF, 4'h0, 4'h3};
    tick(4);
    reset = 1'b1;
    expect_at(t + 5, "rst_mid", '0, '0);
    tick(1);
    reset = 1'b0;
    t = cyc;
    expect_at(t + 5, "rst_mid_early", '0, '0);
    expect_at(t + 6, "rst_mid_accept", 24'h0F0003, 3'b101);
    tick(6);

    // ch1 accepts (unmasked irq source), then its ack
    t = cyc;
    in_raw = {4'hF, 4'h5, 4'h3};
    expect_at(t + 6, "ch1_accept", 24'h0F0503, 3'b111);
    tick(6);
    t = cyc;
    rd_sel = 2'd1; rd_ack = 1'b1;
    expect_at(t + 1, "ack_ch1", 24'h0F0503, 3'b101);
    tick(1);
    rd_ack = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    tick(1);
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
      checks += q.size();
      q.delete();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
